// File: rtl/haraka_pkg.sv
// Shared constants, types and the sponge padding helper for the Haraka-S input packer.
package haraka_pkg;

  localparam int RATE_BITS       = 256;
  localparam int BW              = 8;
  localparam int BYTES_PER_BLOCK = RATE_BITS / BW;
  localparam int COUNT_W         = $clog2(BYTES_PER_BLOCK) + 1;

  localparam logic [BW-1:0] PAD_DS  = 8'h1F;
  localparam logic [BW-1:0] PAD_END = 8'h80;

  typedef logic [RATE_BITS-1:0] block_t;
  typedef logic [COUNT_W-1:0]   count_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HOLD   = 2'd1,
    PADBLK = 2'd2
  } pack_state_t;

  // XOR the domain-separation byte at the first free position and the end byte at
  // the top byte; with count = NB-1 both land on the same byte (0x9F).
  function automatic block_t apply_pad(input block_t blk, input count_t count);
    block_t r;
    r = blk;
    for (int i = 0; i < BYTES_PER_BLOCK; i++) begin
      if (count == count_t'(i)) r[i*BW +: BW] = r[i*BW +: BW] ^ PAD_DS;
    end
    r[RATE_BITS-1 -: BW] = r[RATE_BITS-1 -: BW] ^ PAD_END;
    return r;
  endfunction

endpackage

// File: rtl/byte_block_packer.sv
// Packs an LSB-first byte stream into RATE-bit sponge blocks, pads the final block
// and hands each block downstream over a registered valid/ready interface.
module byte_block_packer
  import haraka_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [BW-1:0]      in_data,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic               in_flush,
  output logic               in_ready,
  output logic [RATE_BITS-1:0] out_word,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam count_t NB = count_t'(BYTES_PER_BLOCK);

  pack_state_t state, state_next;
  logic        live;
  block_t      acc, acc_next, acc_ins;
  count_t      count, count_next, fill_cnt;
  logic        pad_pending, pad_next;
  block_t      word_next;
  count_t      ocount_next;
  logic        olast_next, ovalid_next;

  // in_ready stays low through reset and rises on the first edge after release.
  assign in_ready = live && (state == FILL);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      live        <= 1'b0;
      // NOTE: the accumulator is reset too, not just the control state: unused
      // bytes of a block must read zero, so an aborted message may leave no residue.
      acc         <= '0;
      count       <= '0;
      pad_pending <= 1'b0;
      out_word    <= '0;
      out_count   <= '0;
      out_last    <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_next;
      live        <= 1'b1;
      acc         <= acc_next;
      count       <= count_next;
      pad_pending <= pad_next;
      out_word    <= word_next;
      out_count   <= ocount_next;
      out_last    <= olast_next;
      out_valid   <= ovalid_next;
    end
  end

  // Accumulator with the incoming byte dropped into slot 'count'.
  always_comb begin
    acc_ins  = acc;
    fill_cnt = count + count_t'(1);
    for (int i = 0; i < BYTES_PER_BLOCK; i++) begin
      if (count == count_t'(i)) acc_ins[i*BW +: BW] = in_data;
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    count_next  = count;
    pad_next    = pad_pending;
    word_next   = out_word;
    ocount_next = out_count;
    olast_next  = out_last;
    ovalid_next = out_valid;

    unique case (state)
      FILL: begin
        if (in_valid && in_ready) begin
          if (in_last || fill_cnt == NB) begin
            state_next  = HOLD;
            ovalid_next = 1'b1;
            acc_next    = '0;
            count_next  = '0;
            if (fill_cnt == NB) begin
              // A message ending exactly on a block boundary needs a pad-only block next.
              word_next   = acc_ins;
              ocount_next = NB;
              olast_next  = 1'b0;
              pad_next    = in_last;
            end else begin
              word_next   = apply_pad(acc_ins, fill_cnt);
              ocount_next = fill_cnt;
              olast_next  = 1'b1;
            end
          end else begin
            acc_next   = acc_ins;
            count_next = fill_cnt;
          end
        end else if (in_flush && in_ready && count == '0) begin
          state_next  = HOLD;
          ovalid_next = 1'b1;
          word_next   = apply_pad('0, '0);
          ocount_next = '0;
          olast_next  = 1'b1;
        end
      end

      HOLD: begin
        if (out_ready) begin
          ovalid_next = 1'b0;
          state_next  = pad_pending ? PADBLK : FILL;
        end
      end

      PADBLK: begin
        state_next  = HOLD;
        ovalid_next = 1'b1;
        word_next   = apply_pad('0, '0);
        ocount_next = '0;
        olast_next  = 1'b1;
        pad_next    = 1'b0;
      end

      default: state_next = FILL;
    endcase
  end

endmodule

// File: tb/tb_byte_block_packer.sv
// Directed self-checking bench for byte_block_packer: padding, block boundaries,
// flush, back-pressure and mid-message reset.
module tb_byte_block_packer;
  import haraka_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     in_data;
  logic           in_valid, in_last, in_flush, in_ready;
  logic [255:0]   out_word;
  logic [5:0]     out_count;
  logic           out_last, out_valid, out_ready;

  int checks   = 0;
  int failures = 0;

  byte_block_packer dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_flush  (in_flush),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_count (out_count),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] put(input logic [255:0] b, input int idx, input logic [7:0] v);
    logic [255:0] r;
    r = b;
    r[idx*8 +: 8] = v;
    return r;
  endfunction

  // Starts and ends on a falling edge; the byte is accepted on the rising edge in between.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int g;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) check("send_timeout", {255'd0, in_ready}, 256'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_block(input int hold, output logic [255:0] w, output logic [5:0] c,
                           output logic l);
    int g;
    g = 0;
    while (!out_valid && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("blk_valid", {255'd0, out_valid}, 256'd1);
    w = out_word;
    c = out_count;
    l = out_last;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_word", out_word, w);
      check("hold_meta", {248'd0, out_count, out_last, out_valid}, {248'd0, c, l, 1'b1});
      check("hold_in_ready", {255'd0, in_ready}, 256'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", {255'd0, out_valid}, 256'd0);
  endtask

  logic [255:0] w, exp;
  logic [5:0]   c;
  logic         l;
  logic [255:0] w5 [3];
  logic [5:0]   c5 [3];
  logic         l5 [3];

  initial begin
    reset = 1'b0; in_data = '0; in_valid = 0; in_last = 0; in_flush = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {255'd0, out_valid}, 256'd0);
    check("rst_in_ready", {255'd0, in_ready}, 256'd0);
    check("rst_out_word", out_word, 256'd0);
    check("rst_meta", {248'd0, out_count, out_last, 1'b0}, 256'd0);
    reset = 1'b1;
    #1 check("rel_in_ready_low", {255'd0, in_ready}, 256'd0);
    @(negedge clk);
    check("rel_in_ready_high", {255'd0, in_ready}, 256'd1);

    // 1: three-byte message, checks 1-cycle latency
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 1);
    check("t1_latency", {255'd0, out_valid}, 256'd1);
    get_block(0, w, c, l);
    exp = '0;
    exp = put(exp, 0, 8'h01); exp = put(exp, 1, 8'h02); exp = put(exp, 2, 8'h03);
    exp = put(exp, 3, 8'h1F); exp = put(exp, 31, 8'h80);
    check("t1_word", w, exp);
    check("t1_count", {250'd0, c}, 256'd3);
    check("t1_last", {255'd0, l}, 256'd1);

    // 2: 31-byte message, both pad bytes merge in byte 31
    for (int i = 0; i < 31; i++) send_byte(8'(i), i == 30);
    get_block(0, w, c, l);
    exp = '0;
    for (int i = 0; i < 31; i++) exp = put(exp, i, 8'(i));
    exp = put(exp, 31, 8'h9F);
    check("t2_word", w, exp);
    check("t2_count", {250'd0, c}, 256'd31);
    check("t2_last", {255'd0, l}, 256'd1);

    // 3: exactly one full block, followed by a pad-only block
    for (int i = 0; i < 32; i++) send_byte(8'(i), i == 31);
    get_block(0, w, c, l);
    exp = '0;
    for (int i = 0; i < 32; i++) exp = put(exp, i, 8'(i));
    check("t3_b1_word", w, exp);
    check("t3_b1_count", {250'd0, c}, 256'd32);
    check("t3_b1_last", {255'd0, l}, 256'd0);
    get_block(0, w, c, l);
    exp = '0; exp = put(exp, 0, 8'h1F); exp = put(exp, 31, 8'h80);
    check("t3_b2_word", w, exp);
    check("t3_b2_count", {250'd0, c}, 256'd0);
    check("t3_b2_last", {255'd0, l}, 256'd1);

    // 4: flush when idle, then flush ignored mid-message
    in_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_flush = 1'b0;
    get_block(0, w, c, l);
    check("t4_flush_word", w, exp);
    check("t4_flush_count", {250'd0, c}, 256'd0);
    check("t4_flush_last", {255'd0, l}, 256'd1);
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 0);
    in_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_flush = 1'b0;
    repeat (3) begin
      check("t4_flush_ignored", {255'd0, out_valid}, 256'd0);
      @(negedge clk);
    end
    send_byte(8'h35, 1);
    get_block(0, w, c, l);
    exp = '0;
    for (int i = 0; i < 6; i++) exp = put(exp, i, 8'h30 + 8'(i));
    exp = put(exp, 6, 8'h1F); exp = put(exp, 31, 8'h80);
    check("t4_msg_word", w, exp);
    check("t4_msg_count", {250'd0, c}, 256'd6);

    // 5: 70-byte message with 10 cycles of back-pressure per block
    fork
      for (int i = 0; i < 70; i++) send_byte(8'(i) ^ 8'hA5, i == 69);
      for (int b = 0; b < 3; b++) get_block(10, w5[b], c5[b], l5[b]);
    join
    for (int b = 0; b < 3; b++) begin
      exp = '0;
      for (int i = 0; i < 32; i++)
        if (b * 32 + i < 70) exp = put(exp, i, 8'(b * 32 + i) ^ 8'hA5);
      if (b == 2) begin
        exp = put(exp, 6, 8'h1F);
        exp = put(exp, 31, 8'h80);
      end
      check("t5_word", w5[b], exp);
      check("t5_count", {250'd0, c5[b]}, (b == 2) ? 256'd6 : 256'd32);
      check("t5_last", {255'd0, l5[b]}, (b == 2) ? 256'd1 : 256'd0);
    end

    // 6: reset after 10 bytes, then a clean 2-byte message
    for (int i = 0; i < 10; i++) send_byte(8'hE0 + 8'(i), 0);
    reset = 1'b0;
    #1 check("t6_rst_in_ready", {255'd0, in_ready}, 256'd0);
    @(negedge clk);
    check("t6_rst_out_valid", {255'd0, out_valid}, 256'd0);
    check("t6_rst_in_ready2", {255'd0, in_ready}, 256'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rel_in_ready", {255'd0, in_ready}, 256'd1);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 1);
    get_block(0, w, c, l);
    exp = '0;
    exp = put(exp, 0, 8'hAB); exp = put(exp, 1, 8'hCD);
    exp = put(exp, 2, 8'h1F); exp = put(exp, 31, 8'h80);
    check("t6_word", w, exp);
    check("t6_count", {250'd0, c}, 256'd2);
    check("t6_last", {255'd0, l}, 256'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
